// File: rtl/cong_detector_if.sv
// Sensor and status bundle between the loop front end and its consumers.
// The detector takes the slave view; the traffic-light side or bench takes master.
interface cong_detector_if;
  logic       veh_raw;
  logic       cong;
  logic       veh_det;
  logic [3:0] arrivals;
  logic [1:0] det_state;

  modport master (
    output veh_raw,
    input  cong,
    input  veh_det,
    input  arrivals,
    input  det_state
  );

  modport slave (
    input  veh_raw,
    output cong,
    output veh_det,
    output arrivals,
    output det_state
  );
endinterface

// File: rtl/cong_detector.sv
// Side-road congestion detector: synchronizes and debounces the vehicle loop,
// counts arrivals per fixed window, and raises a held, registered cong flag.
//
// state   | meaning
// IDLE    | no congestion, watching presence time and arrival rate
// CONG    | congestion asserted, minimum hold time running
// RELEASE | hold satisfied and road clear, waiting for OFF_TIME of absence
module cong_detector #(
  parameter int DEB_CYC  = 2,
  parameter int ON_TIME  = 5,
  parameter int OFF_TIME = 3,
  parameter int WIN_LEN  = 30,
  parameter int ARR_TH   = 4,
  parameter int MIN_HOLD = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  cong_detector_if.slave  bus
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int PW = $clog2(ON_TIME + 1);
  localparam int AW = $clog2(OFF_TIME + 1);
  localparam int WW = $clog2(WIN_LEN + 1);
  localparam int HW = $clog2(MIN_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CONG    = 2'b01,
    RELEASE = 2'b10
  } state_t;

  logic          s1, s2;
  logic          veh_det;
  logic [DW-1:0] deb_cnt;
  logic          det_q;
  logic          arr_p;
  logic [WW-1:0] win_cnt;
  logic [3:0]    arrivals;
  logic [PW-1:0] pres_cnt;
  logic [AW-1:0] abs_cnt;
  logic [HW-1:0] hold_cnt;
  state_t        state;
  logic          cong;

  // Two-flop synchronizer for the asynchronous loop sensor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.veh_raw;
      s2 <= s1;
    end
  end

  // Debounce: a change is accepted only after persisting DEB_CYC edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      veh_det <= 1'b0;
      deb_cnt <= '0;
    end else if (s2 == veh_det) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DW'(DEB_CYC - 1)) begin
      veh_det <= s2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Arrival pulse one edge after a rising debounced presence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_q <= 1'b0;
      arr_p <= 1'b0;
    end else begin
      det_q <= veh_det;
      arr_p <= veh_det & ~det_q;
    end
  end

  // Free-running window; an arrival on the wrap edge belongs to the new window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt  <= '0;
      arrivals <= 4'd0;
    end else if (win_cnt == WW'(WIN_LEN - 1)) begin
      win_cnt  <= '0;
      arrivals <= {3'b000, arr_p};
    end else begin
      win_cnt <= win_cnt + 1'b1;
      if (arr_p && (arrivals != 4'hf))
        arrivals <= arrivals + 4'd1;
    end
  end

  // Saturating presence and absence run-length counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pres_cnt <= '0;
      abs_cnt  <= '0;
    end else if (veh_det) begin
      abs_cnt <= '0;
      if (pres_cnt != PW'(ON_TIME))
        pres_cnt <= pres_cnt + 1'b1;
    end else begin
      pres_cnt <= '0;
      if (abs_cnt != AW'(OFF_TIME))
        abs_cnt <= abs_cnt + 1'b1;
    end
  end

  // Congestion FSM with registered cong flag and minimum hold timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cong     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((pres_cnt == PW'(ON_TIME)) || (arrivals >= 4'(ARR_TH))) begin
            state    <= CONG;
            cong     <= 1'b1;
            hold_cnt <= '0;
          end
        end
        CONG: begin
          if (hold_cnt != HW'(MIN_HOLD))
            hold_cnt <= hold_cnt + 1'b1;
          if ((hold_cnt == HW'(MIN_HOLD)) && !veh_det)
            state <= RELEASE;
        end
        RELEASE: begin
          // Returning traffic wins over an expiring absence timer.
          if (veh_det) begin
            state <= CONG;
          end else if (abs_cnt == AW'(OFF_TIME)) begin
            state <= IDLE;
            cong  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cong  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cong      = cong;
  assign bus.veh_det   = veh_det;
  assign bus.arrivals  = arrivals;
  assign bus.det_state = state;

endmodule

// File: tb/tb_cong_detector.sv
// Bench for cong_detector: directed scenarios plus random sensor activity,
// all compared each cycle against a behavioural model of the detector rules.
module tb_cong_detector;

  localparam int DEB_CYC  = 2;
  localparam int ON_TIME  = 5;
  localparam int OFF_TIME = 3;
  localparam int WIN_LEN  = 30;
  localparam int ARR_TH   = 4;
  localparam int MIN_HOLD = 10;

  logic clk;
  logic rst_n;
  cong_detector_if bus ();

  cong_detector #(
    .DEB_CYC (DEB_CYC),
    .ON_TIME (ON_TIME),
    .OFF_TIME(OFF_TIME),
    .WIN_LEN (WIN_LEN),
    .ARR_TH  (ARR_TH),
    .MIN_HOLD(MIN_HOLD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Model state: raw histories and run lengths rather than bounded counters.
  int m_s1, m_s2, m_det, m_det_prev, m_arrp;
  int m_hi_run, m_lo_run, m_n, m_arr, m_mode, m_hold;
  int hist[$];
  int arr_edges[$];
  int rel_seen;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at time %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_det = 0; m_det_prev = 0; m_arrp = 0;
    m_hi_run = 0; m_lo_run = 0; m_n = 0; m_arr = 0; m_mode = 0; m_hold = 0;
    hist.delete();
    arr_edges.delete();
  endtask

  task automatic model_step(input int v);
    int o_det, o_s2, o_pres, o_abs, consume, ws, cnt;
    bit all_diff;
    o_det  = m_det;
    o_s2   = m_s2;
    o_pres = (m_hi_run > ON_TIME) ? ON_TIME : m_hi_run;
    o_abs  = (m_lo_run > OFF_TIME) ? OFF_TIME : m_lo_run;

    case (m_mode)
      0: if (o_pres == ON_TIME || m_arr >= ARR_TH) begin m_mode = 1; m_hold = 0; end
      1: begin
        if (m_hold == MIN_HOLD && o_det == 0) m_mode = 2;
        if (m_hold < MIN_HOLD) m_hold++;
      end
      default: if (o_det == 1) m_mode = 1; else if (o_abs == OFF_TIME) m_mode = 0;
    endcase

    if (o_det == 1) begin m_hi_run++; m_lo_run = 0; end
    else begin m_lo_run++; m_hi_run = 0; end

    // Arrival counted in the window containing the edge that consumes the pulse.
    consume = m_arrp;
    if (consume == 1) arr_edges.push_back(m_n);
    m_arrp = (o_det == 1 && m_det_prev == 0) ? 1 : 0;
    m_det_prev = o_det;
    ws = ((m_n + 1) >= WIN_LEN) ? ((m_n + 1) / WIN_LEN) * WIN_LEN - 1 : 0;
    cnt = 0;
    foreach (arr_edges[i]) if (arr_edges[i] >= ws) cnt++;
    m_arr = (cnt > 15) ? 15 : cnt;

    // Accept a change once the last DEB_CYC synchronized samples all disagree.
    hist.push_back(o_s2);
    if (hist.size() > DEB_CYC) void'(hist.pop_front());
    all_diff = (hist.size() == DEB_CYC);
    foreach (hist[i]) if (hist[i] == o_det) all_diff = 0;
    if (all_diff) m_det = 1 - o_det;

    m_s2 = m_s1;
    m_s1 = v;
    m_n++;
  endtask

  task automatic compare_all();
    chk("veh_det",   int'(bus.veh_det),   m_det);
    chk("arrivals",  int'(bus.arrivals),  m_arr);
    chk("det_state", int'(bus.det_state), m_mode);
    chk("cong",      int'(bus.cong),      (m_mode != 0) ? 1 : 0);
    if (bus.det_state == 2'b10) rel_seen++;
  endtask

  task automatic cyc(input logic v);
    bus.veh_raw = v;
    @(posedge clk);
    model_step(int'(v));
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset(input logic v);
    bus.veh_raw = v;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_cong",  int'(bus.cong), 0);
    chk("rst_state", int'(bus.det_state), 0);
    chk("rst_det",   int'(bus.veh_det), 0);
    chk("rst_arr",   int'(bus.arrivals), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; rel_seen = 0;
    bus.veh_raw = 1'b0;
    rst_n = 1'b1;
    model_reset();
    #3;

    // Held presence: veh_det after edge 3, cong after edge 9.
    do_reset(1'b1);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1);
      if (i == 2) chk("lat_det_pre",  int'(bus.veh_det), 0);
      if (i == 3) chk("lat_det",      int'(bus.veh_det), 1);
      if (i == 8) chk("lat_cong_pre", int'(bus.cong), 0);
      if (i == 9) begin
        chk("lat_cong",  int'(bus.cong), 1);
        chk("lat_state", int'(bus.det_state), 1);
      end
    end
    // Sensor clears early in the hold: cong held, then RELEASE, then IDLE.
    rel_seen = 0;
    for (int i = 0; i < 25; i++) cyc(1'b0);
    chk("release_seen", (rel_seen > 0) ? 1 : 0, 1);
    chk("release_end",  int'(bus.cong), 0);

    // Single-cycle glitch is rejected.
    do_reset(1'b1);
    cyc(1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0);
    chk("glitch_det", int'(bus.veh_det), 0);
    chk("glitch_arr", int'(bus.arrivals), 0);

    // Four short pulses inside one window trigger on arrival count.
    do_reset(1'b0);
    for (int i = 0; i < 25; i++) cyc(1'b0);
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 4; i++) cyc(1'b1);
      for (int i = 0; i < 4; i++) cyc(1'b0);
    end
    // edges 25..56 done; arrivals=4 after edge 54, cong after 55
    chk("arr4_cong", int'(bus.cong), 1);
    for (int i = 0; i < 20; i++) cyc(1'b0);

    // Asynchronous reset in CONG clears cong without a clock edge.
    do_reset(1'b1);
    for (int i = 0; i < 11; i++) cyc(1'b1);
    chk("pre_rst_cong", int'(bus.cong), 1);
    #2;
    do_reset(1'b0);

    // Arrival consumed on the wrap edge counts in the new window.
    for (int i = 0; i < 24; i++) cyc(1'b0);
    for (int i = 24; i < 30; i++) begin
      cyc(1'b1);
      if (i == 28) chk("wrap_arr_pre", int'(bus.arrivals), 0);
      if (i == 29) chk("wrap_arr",     int'(bus.arrivals), 1);
    end
    for (int i = 0; i < 20; i++) cyc(1'b0);

    // Random sensor activity, including glitches and re-entry from RELEASE.
    for (int s = 0; s < 90; s++) begin
      logic lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 14));
      for (int i = 0; i < len; i++) cyc(lvl);
      if (s == 45) do_reset(1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cong_detector.md
CONG_DETECTOR -- requirements
Module: cong_detector

Interface
REQ-001 Parameter DEB_CYC, default 2: consecutive cycles a synchronized sensor change must persist before acceptance.
REQ-002 Parameter ON_TIME, default 5: consecutive presence cycles that trigger congestion.
REQ-003 Parameter OFF_TIME, default 3: consecutive absence cycles that end congestion.
REQ-004 Parameter WIN_LEN, default 30: arrival-count window length in cycles.
REQ-005 Parameter ARR_TH, default 4: arrivals per window that trigger congestion (1..15).
REQ-006 Parameter MIN_HOLD, default 10: minimum cycles cong stays high once set.
REQ-007 clk  input  1  system clock, 1 Hz, rising edge active; the only clock in the block.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 veh_raw  input  1  raw side-road vehicle loop sensor, asynchronous to clk; 1 = vehicle over loop.
REQ-010 cong  output  1  registered congestion flag, consumed directly by the traffic-light controller's cong input.
REQ-011 veh_det  output  1  debounced vehicle presence.
REQ-012 arrivals  output  4  arrival count in the current window, saturating.
REQ-013 det_state  output  2  FSM state: 00 IDLE, 01 CONG, 10 RELEASE.

Function
REQ-014 veh_raw SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-015 On each edge, if s2 equals veh_det, deb_cnt SHALL clear to 0.
REQ-016 On each edge, if s2 differs from veh_det, deb_cnt SHALL increment; on the edge where it would reach DEB_CYC, veh_det SHALL take s2 and deb_cnt SHALL clear.
REQ-017 A veh_raw level lasting fewer than DEB_CYC cycles at s2 SHALL NOT change veh_det.
REQ-018 An arrival SHALL be a 0->1 transition of veh_det, flagged as a one-cycle internal pulse arr_p on the following edge.
REQ-019 win_cnt SHALL count 0..WIN_LEN-1 freely and wrap to 0.
REQ-020 On the wrap edge, arrivals SHALL load arr_p (0 or 1), so an arrival coincident with the wrap counts in the new window.
REQ-021 Otherwise arrivals SHALL increment on arr_p and saturate at 15.
REQ-022 pres_cnt SHALL increment each edge veh_det=1, saturate at ON_TIME, and clear when veh_det=0.
REQ-023 abs_cnt SHALL increment each edge veh_det=0, saturate at OFF_TIME, and clear when veh_det=1.
REQ-024 IDLE -> CONG when pres_cnt==ON_TIME or arrivals>=ARR_TH; on that edge cong becomes 1 and hold_cnt clears.
REQ-025 In CONG, hold_cnt SHALL increment each edge and saturate at MIN_HOLD.
REQ-026 CONG -> RELEASE when hold_cnt==MIN_HOLD and veh_det==0; cong stays 1.
REQ-027 RELEASE -> CONG when veh_det==1; hold_cnt is not cleared and stays at MIN_HOLD.
REQ-028 RELEASE -> IDLE when abs_cnt==OFF_TIME; on that edge cong becomes 0.
REQ-029 If both exit conditions hold in RELEASE on the same edge, RELEASE -> CONG SHALL take priority.
REQ-030 cong SHALL be 1 exactly in CONG and RELEASE, and SHALL be driven from a flop with no combinational path from veh_raw.
REQ-031 Overall latency SHALL be fixed: with veh_raw held high from before edge k and the FSM in IDLE, cong rises at edge k+DEB_CYC+ON_TIME+2.
REQ-032 All counters SHALL be sized to hold their parameter maximum without overflow.

Reset
REQ-033 rst_n=0 SHALL immediately clear s1, s2, veh_det, all counters, arrivals and cong, and force IDLE, in any state including mid-CONG.
REQ-034 After rst_n rises, the first active edge SHALL behave as normal operation from that all-zero state.

Verification
REQ-035 veh_raw 0->1 before edge 0, held high -> veh_det=1 after edge 3; cong=1 after edge 9; det_state=01.
REQ-036 veh_raw high for exactly 1 cycle -> veh_det, arrivals and cong remain 0.
REQ-037 Four 4-cycle-high / 4-cycle-low pulses within one window -> arrivals counts 1..4; cong=1 on the edge after arrivals=4.
REQ-038 cong set, then sensor clears at hold_cnt=3 -> cong stays 1 until MIN_HOLD is reached, then RELEASE, then 0 after OFF_TIME absent cycles.
REQ-039 In RELEASE, sensor returns after 2 absent cycles -> FSM returns to CONG with cong continuously 1; a later 3-cycle absence returns the FSM to IDLE.
REQ-040 rst_n pulsed low while in CONG -> cong=0 without waiting for a clock edge; an arrival on the wrap edge -> arrivals=1 in the new window.
